// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard FIFO: receiver state encoding,
// scan-code prefix constants, FIFO entry layout and scan-to-ASCII mapping.
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXTEND = 8'hE0;

    // FIFO entry layout: {brk, ext, code[7:0]}
    localparam int ENTRY_CODE_LSB = 0;
    localparam int ENTRY_EXT_BIT  = 8;
    localparam int ENTRY_BRK_BIT  = 9;
    localparam int ENTRY_W        = 10;

    // Scan-code set 2 to ASCII; anything unmapped reads back as '?'
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc);
        logic [7:0] a;
        case (sc)
            8'h29: a = 8'h20;
            8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
            8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
            8'h3E: a = "8";  8'h46: a = "9";
            8'h1C: a = "A";  8'h32: a = "B";  8'h21: a = "C";  8'h23: a = "D";
            8'h24: a = "E";  8'h2B: a = "F";  8'h34: a = "G";  8'h33: a = "H";
            8'h43: a = "I";  8'h3B: a = "J";  8'h42: a = "K";  8'h4B: a = "L";
            8'h3A: a = "M";  8'h31: a = "N";  8'h44: a = "O";  8'h4D: a = "P";
            8'h15: a = "Q";  8'h2D: a = "R";  8'h1B: a = "S";  8'h2C: a = "T";
            8'h3C: a = "U";  8'h2A: a = "V";  8'h1D: a = "W";  8'h22: a = "X";
            8'h35: a = "Y";  8'h1A: a = "Z";
            default: a = 8'd63;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the PS/2 lines, walks start/data/parity/stop
// on each falling PS/2 clock edge and aborts a stalled frame after TIMEOUT_CYCLES.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err_pulse
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev;
    logic          fall, din;
    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_err;
    logic [TW-1:0] tcnt;

    assign fall = clk_prev & ~clk_sync[1];
    assign din  = data_sync[1];

    // Two-flop synchronisers plus a previous-sample flop for edge detection; idle-high lines
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    // Receiver FSM with stall timeout; byte_valid and frame_err_pulse are single-cycle
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            state           <= RX_IDLE;
            bit_cnt         <= '0;
            shift           <= '0;
            par_err         <= 1'b0;
            tcnt            <= '0;
            byte_valid      <= 1'b0;
            rx_byte         <= '0;
            frame_err_pulse <= 1'b0;
        end else begin
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
            if (state != RX_IDLE && !fall) begin
                if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state           <= RX_IDLE;
                    tcnt            <= '0;
                    bit_cnt         <= '0;
                    shift           <= '0;
                    frame_err_pulse <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else if (fall) begin
                tcnt <= '0;
                case (state)
                    RX_IDLE: begin
                        if (!din) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shift   <= {din, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_err <= ~(^shift ^ din);
                        state   <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (din && !par_err) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shift;
                        end else begin
                            frame_err_pulse <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard controller: frame receiver, break/extend prefix decoder, key-event
// FIFO and a two-register read-only bus port (data at BASE_ADDRESS, status at +1).
// Define PS2_KEYBOARD_ASCII_EN to translate scan codes to ASCII on the data register.
module ps2_keyboard_fifo
    import ps2_pkg::*;
#(
    parameter logic [13:0] BASE_ADDRESS   = 14'h2500,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          TIMEOUT_CYCLES = 20000
) (
    input  logic        system_clk,
    input  logic        reset,
    input  logic [13:0] address,
    input  logic        read,
    input  logic        PS2_clk,
    input  logic        PS2_data,
    output logic [63:0] data,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic               byte_valid, frame_err_pulse;
    logic [7:0]         rx_byte;
    logic               brk_flag, ext_flag;
    logic               push_req, push_ok, pop;
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wptr, rptr;
    logic [CW-1:0]      count;
    logic               empty, full;
    logic               data_sel, stat_sel, data_sel_q, stat_sel_q, stat_first;
    logic               overflow, frame_err;
    logic [ENTRY_W-1:0] head;
    logic [7:0]         code_out;
    logic [63:0]        data_reg, status_reg;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .system_clk      (system_clk),
        .reset           (reset),
        .ps2_clk         (PS2_clk),
        .ps2_data        (PS2_data),
        .byte_valid      (byte_valid),
        .rx_byte         (rx_byte),
        .frame_err_pulse (frame_err_pulse)
    );

    assign empty      = (count == '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign irq        = !empty;
    assign push_req   = byte_valid && rx_byte != SC_BREAK && rx_byte != SC_EXTEND;
    assign data_sel   = read && address == BASE_ADDRESS;
    assign stat_sel   = read && address == BASE_ADDRESS + 14'd1;
    assign stat_first = stat_sel && !stat_sel_q;
    assign pop        = data_sel && !data_sel_q && !empty;
    // A full FIFO still takes the push when the head leaves in the same cycle
    assign push_ok    = push_req && (!full || pop);

    // Prefix flags accumulate until the next real key code consumes them
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == SC_BREAK)       brk_flag <= 1'b1;
            else if (rx_byte == SC_EXTEND) ext_flag <= 1'b1;
            else begin
                brk_flag <= 1'b0;
                ext_flag <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge system_clk) begin
        if (push_ok) mem[wptr] <= {brk_flag, ext_flag, rx_byte};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered selects for first-cycle detection, plus sticky fault bits
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            data_sel_q <= 1'b0;
            stat_sel_q <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_sel_q <= data_sel;
            stat_sel_q <= stat_sel;
            if (push_req && !push_ok) overflow  <= 1'b1;
            else if (stat_first)      overflow  <= 1'b0;
            if (frame_err_pulse)      frame_err <= 1'b1;
            else if (stat_first)      frame_err <= 1'b0;
        end
    end

    assign head = mem[rptr];

`ifdef PS2_KEYBOARD_ASCII_EN
    assign code_out = scan_to_ascii(head[ENTRY_CODE_LSB +: 8]);
`else
    assign code_out = head[ENTRY_CODE_LSB +: 8];
`endif

    assign data_reg   = empty ? 64'd0
                              : {53'd0, 1'b1, head[ENTRY_BRK_BIT], head[ENTRY_EXT_BIT], code_out};
    assign status_reg = {48'd0, 8'(count), 4'd0, frame_err, overflow, full, !empty};
    assign data       = data_sel ? data_reg : (stat_sel ? status_reg : 64'bz);

endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Directed bench for ps2_keyboard_fifo: bit-banged PS/2 frames and bus reads,
// expected values written out by hand (raw or ASCII depending on PS2_KEYBOARD_ASCII_EN).
module tb_ps2_keyboard_fifo;

    localparam logic [13:0] BASE = 14'h2500;
    localparam int          TMO  = 300;

    logic        system_clk = 1'b0;
    logic        reset      = 1'b1;
    logic [13:0] address    = '0;
    logic        read       = 1'b0;
    logic        PS2_clk    = 1'b1;
    logic        PS2_data   = 1'b1;
    wire  [63:0] data;
    wire         irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] v;
    logic [7:0]  codes [9];
    logic [7:0]  chars [9];

`ifdef PS2_KEYBOARD_ASCII_EN
    localparam logic [63:0] EXP_1C    = 64'h441;
    localparam logic [63:0] EXP_F01C  = 64'h641;
    localparam logic [63:0] EXP_E0F075 = 64'h73F;
    localparam logic [63:0] EXP_32    = 64'h442;
`else
    localparam logic [63:0] EXP_1C    = 64'h41C;
    localparam logic [63:0] EXP_F01C  = 64'h61C;
    localparam logic [63:0] EXP_E0F075 = 64'h775;
    localparam logic [63:0] EXP_32    = 64'h432;
`endif

    ps2_keyboard_fifo #(
        .BASE_ADDRESS   (BASE),
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .system_clk (system_clk),
        .reset      (reset),
        .address    (address),
        .read       (read),
        .PS2_clk    (PS2_clk),
        .PS2_data   (PS2_data),
        .data       (data),
        .irq        (irq)
    );

    always #5 system_clk = ~system_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge system_clk);
    endtask

    // One PS/2 bit: data set up, clock low for 10 cycles, clock high again
    task automatic send_bit(input logic b);
        PS2_data = b;
        wait_cyc(5);
        PS2_clk = 1'b0;
        wait_cyc(10);
        PS2_clk = 1'b1;
        wait_cyc(5);
    endtask

    // First n bits of a frame, LSB first: start, 8 data, parity, stop
    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int n);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < n; i++) send_bit(f[i]);
        PS2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    // Single-cycle bus read, sampled mid-cycle
    task automatic bus_read(input logic [13:0] a, output logic [63:0] val);
        @(negedge system_clk);
        address = a;
        read    = 1'b1;
        #1 val  = data;
        @(negedge system_clk);
        read    = 1'b0;
    endtask

    initial begin
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        chars = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        wait_cyc(3);
        @(negedge system_clk);
        reset = 1'b0;
        wait_cyc(2);

        // Reset state
        #1 check("reset_irq", {63'd0, irq}, 64'd0);
        bus_read(BASE + 14'd1, v); check("reset_status", v, 64'd0);
        bus_read(BASE, v);         check("reset_data", v, 64'd0);

        // Single key 1C
        send_frame(8'h1C);
        #1 check("1c_irq", {63'd0, irq}, 64'd1);
        bus_read(BASE + 14'd1, v); check("1c_status", v, 64'h101);
        bus_read(BASE, v);         check("1c_data", v, EXP_1C);
        #1 check("1c_irq_after_pop", {63'd0, irq}, 64'd0);
        bus_read(BASE, v);         check("empty_data", v, 64'd0);

        // Break prefix
        send_frame(8'hF0);
        send_frame(8'h1C);
        bus_read(BASE + 14'd1, v); check("brk_status", v, 64'h101);
        bus_read(BASE, v);         check("brk_data", v, EXP_F01C);

        // Extended break
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        bus_read(BASE, v);         check("ext_brk_data", v, EXP_E0F075);

        // Parity fault
        send_bits(8'h1C, 1'b1, 11);
        #1 check("par_irq", {63'd0, irq}, 64'd0);
        bus_read(BASE + 14'd1, v); check("par_status", v, 64'h8);
        bus_read(BASE + 14'd1, v); check("par_status_cleared", v, 64'h0);

        // Nine frames into an 8-deep FIFO
        for (int i = 0; i < 9; i++) send_frame(codes[i]);
        bus_read(BASE + 14'd1, v); check("ovf_status", v, 64'h807);
        bus_read(BASE + 14'd1, v); check("ovf_status_cleared", v, 64'h803);

        // Held read pops only once
        @(negedge system_clk);
        address = BASE;
        read    = 1'b1;
`ifdef PS2_KEYBOARD_ASCII_EN
        #1 check("held_read_0", data, {53'd0, 3'b100, chars[0]});
`else
        #1 check("held_read_0", data, {53'd0, 3'b100, codes[0]});
`endif
        wait_cyc(3);
        @(negedge system_clk);
        read = 1'b0;
        bus_read(BASE + 14'd1, v); check("held_read_status", v, 64'h701);
        for (int i = 1; i < 8; i++) begin
            bus_read(BASE, v);
`ifdef PS2_KEYBOARD_ASCII_EN
            check($sformatf("drain_%0d", i), v, {53'd0, 3'b100, chars[i]});
`else
            check($sformatf("drain_%0d", i), v, {53'd0, 3'b100, codes[i]});
`endif
        end
        bus_read(BASE + 14'd1, v); check("drained_status", v, 64'h0);

        // Stalled frame times out
        send_bits(8'h1C, 1'b0, 5);
        wait_cyc(TMO + 20);
        bus_read(BASE + 14'd1, v); check("timeout_status", v, 64'h8);
        bus_read(BASE + 14'd1, v); check("timeout_status_cleared", v, 64'h0);
        send_frame(8'h1C);
        bus_read(BASE, v);         check("after_timeout_data", v, EXP_1C);

        // Reset mid-frame with three entries queued
        send_frame(8'h1C);
        send_frame(8'h32);
        send_frame(8'h21);
        bus_read(BASE + 14'd1, v); check("three_status", v, 64'h301);
        send_bits(8'h1C, 1'b0, 6);
        @(negedge system_clk);
        reset = 1'b1;
        wait_cyc(3);
        @(negedge system_clk);
        reset = 1'b0;
        #1 check("midreset_irq", {63'd0, irq}, 64'd0);
        bus_read(BASE + 14'd1, v); check("midreset_status", v, 64'h0);
        bus_read(BASE, v);         check("midreset_data", v, 64'h0);
        wait_cyc(10);
        send_frame(8'h32);
        bus_read(BASE, v);         check("after_reset_data", v, EXP_32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
